// File: rtl/bsg_axi_pkg.sv
// bsg_axi_pkg: shared AXI burst/response encodings and the line-master state enum
package bsg_axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    RESET,
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } line_master_state_e;

endpackage

// File: rtl/bsg_axi_line_master_buf.sv
// bsg_axi_line_master_buf: line buffer with full-line load, beat write port and beat read mux
module bsg_axi_line_master_buf #(
  parameter  int data_width_p  = 64,
  parameter  int burst_len_p   = 4,
  localparam int idx_width_lp  = $clog2(burst_len_p),
  localparam int line_width_lp = data_width_p*burst_len_p
) (
  input  logic                     clk_i,
  input  logic                     load_i,
  input  logic [line_width_lp-1:0] line_i,
  input  logic                     w_v_i,
  input  logic [idx_width_lp-1:0]  w_idx_i,
  input  logic [data_width_p-1:0]  w_data_i,
  input  logic [idx_width_lp-1:0]  r_idx_i,
  output logic [data_width_p-1:0]  r_data_o,
  output logic [line_width_lp-1:0] line_o
);

  logic [burst_len_p-1:0][data_width_p-1:0] beats_r;

  // whole-line load on request accept, otherwise one read beat at a time
  always_ff @(posedge clk_i)
    if (load_i) beats_r <= line_i;
    else if (w_v_i) beats_r[w_idx_i] <= w_data_i;

  assign r_data_o = beats_r[r_idx_i];
  assign line_o   = beats_r;

endmodule

// File: rtl/bsg_axi_line_master.sv
// bsg_axi_line_master: one-line-per-INCR-burst AXI4 initiator; BSG_AXI_LINE_MASTER_ID_CHECK_EN flags bid/rid mismatches
module bsg_axi_line_master
  import bsg_axi_pkg::*;
#(
  parameter  int axi_id_width_p    = 4,
  parameter  int axi_addr_width_p  = 32,
  parameter  int axi_data_width_p  = 64,
  parameter  int axi_burst_len_p   = 4,
  localparam int line_width_lp     = axi_data_width_p*axi_burst_len_p,
  localparam int axi_strb_width_lp = axi_data_width_p>>3
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         req_v_i,
  output logic                         req_ready_o,
  input  logic                         req_write_i,
  input  logic [axi_addr_width_p-1:0]  req_addr_i,
  input  logic [line_width_lp-1:0]     req_data_i,
  output logic                         resp_v_o,
  input  logic                         resp_yumi_i,
  output logic [line_width_lp-1:0]     resp_data_o,
  output logic                         resp_err_o,
  output logic [axi_id_width_p-1:0]    axi_awid_o,
  output logic [axi_addr_width_p-1:0]  axi_awaddr_o,
  output logic [7:0]                   axi_awlen_o,
  output logic [1:0]                   axi_awburst_o,
  output logic                         axi_awvalid_o,
  input  logic                         axi_awready_i,
  output logic [axi_data_width_p-1:0]  axi_wdata_o,
  output logic [axi_strb_width_lp-1:0] axi_wstrb_o,
  output logic                         axi_wlast_o,
  output logic                         axi_wvalid_o,
  input  logic                         axi_wready_i,
  input  logic [axi_id_width_p-1:0]    axi_bid_i,
  input  logic [1:0]                   axi_bresp_i,
  input  logic                         axi_bvalid_i,
  output logic                         axi_bready_o,
  output logic [axi_id_width_p-1:0]    axi_arid_o,
  output logic [axi_addr_width_p-1:0]  axi_araddr_o,
  output logic [7:0]                   axi_arlen_o,
  output logic [1:0]                   axi_arburst_o,
  output logic                         axi_arvalid_o,
  input  logic                         axi_arready_i,
  input  logic [axi_id_width_p-1:0]    axi_rid_i,
  input  logic [axi_data_width_p-1:0]  axi_rdata_i,
  input  logic [1:0]                   axi_rresp_i,
  input  logic                         axi_rlast_i,
  input  logic                         axi_rvalid_i,
  output logic                         axi_rready_o
);

  localparam int cnt_width_lp = $clog2(axi_burst_len_p);
  localparam logic [cnt_width_lp-1:0] last_lp = cnt_width_lp'(axi_burst_len_p-1);
  localparam logic [axi_addr_width_p-1:0] align_mask_lp = ~axi_addr_width_p'(axi_strb_width_lp-1);

  line_master_state_e state_r, state_n;
  logic [axi_id_width_p-1:0]   id_r, id_n;
  logic [axi_addr_width_p-1:0] addr_r, addr_n;
  logic [cnt_width_lp-1:0]     cnt_r, cnt_n;
  logic err_r, err_n, load, beat_w_v, last, bid_err, rid_err;

`ifdef BSG_AXI_LINE_MASTER_ID_CHECK_EN
  assign bid_err = axi_bid_i != id_r;
  assign rid_err = axi_rid_i != id_r;
`else
  logic unused_ids;
  assign unused_ids = ^{axi_bid_i, axi_rid_i};
  assign bid_err = 1'b0;
  assign rid_err = 1'b0;
`endif

  assign last          = cnt_r == last_lp;
  assign axi_awid_o    = id_r;
  assign axi_arid_o    = id_r;
  assign axi_awaddr_o  = addr_r;
  assign axi_araddr_o  = addr_r;
  assign axi_awlen_o   = 8'(axi_burst_len_p-1);
  assign axi_arlen_o   = 8'(axi_burst_len_p-1);
  assign axi_awburst_o = INCR;
  assign axi_arburst_o = INCR;
  assign axi_wstrb_o   = '1;
  assign resp_err_o    = err_r;

  bsg_axi_line_master_buf #(
    .data_width_p(axi_data_width_p),
    .burst_len_p (axi_burst_len_p)
  ) line_buf (
    .clk_i   (clk_i),
    .load_i  (load),
    .line_i  (req_data_i),
    .w_v_i   (beat_w_v),
    .w_idx_i (cnt_r),
    .w_data_i(axi_rdata_i),
    .r_idx_i (cnt_r),
    .r_data_o(axi_wdata_o),
    .line_o  (resp_data_o)
  );

  // state and transaction registers; reset abandons any transaction in flight
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_r <= RESET;
      id_r    <= '0;
      addr_r  <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      id_r    <= id_n;
      addr_r  <= addr_n;
      cnt_r   <= cnt_n;
      err_r   <= err_n;
    end

  // next-state, handshake outputs and register updates per state
  always_comb begin
    state_n       = state_r;
    id_n          = id_r;
    addr_n        = addr_r;
    cnt_n         = cnt_r;
    err_n         = err_r;
    load          = 1'b0;
    beat_w_v      = 1'b0;
    req_ready_o   = 1'b0;
    resp_v_o      = 1'b0;
    axi_awvalid_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    axi_wlast_o   = 1'b0;
    axi_bready_o  = 1'b0;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;
    case (state_r)
      RESET: state_n = IDLE;
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_v_i) begin
          addr_n  = req_addr_i & align_mask_lp;
          load    = 1'b1;
          state_n = req_write_i ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        axi_awvalid_o = 1'b1;
        if (axi_awready_i) begin
          cnt_n   = '0;
          state_n = WR_DATA;
        end
      end
      WR_DATA: begin
        axi_wvalid_o = 1'b1;
        axi_wlast_o  = last;
        if (axi_wready_i) begin
          cnt_n   = cnt_r + 1'b1;
          state_n = last ? WR_RESP : WR_DATA;
        end
      end
      WR_RESP: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) begin
          err_n   = err_r | (axi_bresp_i != OKAY) | bid_err;
          state_n = DONE;
        end
      end
      RD_ADDR: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) begin
          cnt_n   = '0;
          state_n = RD_DATA;
        end
      end
      RD_DATA: begin
        axi_rready_o = 1'b1;
        if (axi_rvalid_i) begin
          beat_w_v = 1'b1;
          err_n    = err_r | (axi_rresp_i != OKAY) | (axi_rlast_i != last) | rid_err;
          cnt_n    = cnt_r + 1'b1;
          state_n  = last ? DONE : RD_DATA;
        end
      end
      DONE: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) begin
          err_n   = 1'b0;
          id_n    = id_r + 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = RESET;
    endcase
  end

endmodule

// File: tb/tb_bsg_axi_line_master.sv
// tb_bsg_axi_line_master: directed tests of the line master against a behavioural AXI memory
module tb_bsg_axi_line_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_i, req_v_i, req_ready_o, req_write_i, resp_v_o, resp_yumi_i, resp_err_o;
  logic [31:0]  req_addr_i;
  logic [255:0] req_data_i, resp_data_o;
  logic [3:0]   axi_awid_o, axi_arid_o, axi_bid_i, axi_rid_i;
  logic [31:0]  axi_awaddr_o, axi_araddr_o;
  logic [7:0]   axi_awlen_o, axi_arlen_o, axi_wstrb_o;
  logic [1:0]   axi_awburst_o, axi_arburst_o, axi_bresp_i, axi_rresp_i;
  logic         axi_awvalid_o, axi_awready_i, axi_wlast_o, axi_wvalid_o, axi_wready_i;
  logic         axi_bvalid_i, axi_bready_o, axi_arvalid_o, axi_arready_i;
  logic         axi_rlast_i, axi_rvalid_i, axi_rready_o;
  logic [63:0]  axi_wdata_o, axi_rdata_i;

  bsg_axi_line_master dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
    .axi_awburst_o(axi_awburst_o), .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_bid_i(axi_bid_i), .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
    .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
    .axi_arburst_o(axi_arburst_o), .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
  );

  localparam logic [255:0] line1 = {64'h4444444444444444, 64'h3333333333333333,
                                    64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] line2 = {64'hdddd0004cafe0004, 64'hcccc0003beef0003,
                                    64'hbbbb0002f00d0002, 64'haaaa0001abcd0001};

  int vectors = 0, miscompares = 0;

  // behavioural responder state and knobs
  logic [63:0] mem [256];
  logic [63:0] wd [16];
  logic        wl [16];
  int          wn = 0, wbeat = 0, rbeat = 0, err_beat = -1, early_beat = -1, id_off = 0;
  logic        wr_pend = 0, b_pend = 0, rd_active = 0, w_before_aw = 0, stall_en = 0;
  logic [31:0] aw_addr_q = 0, ar_addr_q = 0;
  logic [3:0]  aw_id_q = 0, ar_id_q = 0;
  logic [7:0]  aw_len_q = 0, ar_len_q = 0;
  logic [1:0]  aw_burst_q = 0, ar_burst_q = 0;

  function automatic int idx(input logic [31:0] a, input int b);
    return (int'(a[10:3]) + b) & 255;
  endfunction

  function automatic logic go();
    return !stall_en || ($urandom_range(0, 2) != 0);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    axi_awready_i = 0; axi_wready_i = 0; axi_arready_i = 0;
    axi_bvalid_i = 0; axi_bid_i = 0; axi_bresp_i = 0;
    axi_rvalid_i = 0; axi_rid_i = 0; axi_rdata_i = 0; axi_rresp_i = 0; axi_rlast_i = 0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        wr_pend = 0; b_pend = 0; rd_active = 0; rbeat = 0; wbeat = 0;
      end else begin
        if (axi_wvalid_o && axi_wready_i) begin
          if (!wr_pend) w_before_aw = 1;
          mem[idx(aw_addr_q, wbeat)] = axi_wdata_o;
          if (wn < 16) begin wd[wn] = axi_wdata_o; wl[wn] = axi_wlast_o; end
          wn++; wbeat++;
          if (axi_wlast_o) begin wr_pend = 0; b_pend = 1; end
        end
        if (axi_awvalid_o && axi_awready_i) begin
          wr_pend = 1; wbeat = 0; aw_addr_q = axi_awaddr_o; aw_id_q = axi_awid_o;
          aw_len_q = axi_awlen_o; aw_burst_q = axi_awburst_o;
        end
        if (axi_bvalid_i && axi_bready_o) b_pend = 0;
        if (axi_rvalid_i && axi_rready_o) begin
          rbeat++;
          if (rbeat == 4) rd_active = 0;
        end
        if (axi_arvalid_o && axi_arready_i) begin
          rd_active = 1; rbeat = 0; ar_addr_q = axi_araddr_o; ar_id_q = axi_arid_o;
          ar_len_q = axi_arlen_o; ar_burst_q = axi_arburst_o;
        end
      end
      @(posedge clk); #1;
      axi_awready_i = go(); axi_wready_i = go(); axi_arready_i = go();
      axi_bvalid_i = b_pend && go(); axi_bid_i = 4'(int'(aw_id_q) + id_off); axi_bresp_i = 2'b00;
      axi_rvalid_i = rd_active && go(); axi_rdata_i = mem[idx(ar_addr_q, rbeat)];
      axi_rresp_i = (rbeat == err_beat) ? 2'b10 : 2'b00;
      axi_rlast_i = (rbeat == 3) || (rbeat == early_beat);
      axi_rid_i = 4'(int'(ar_id_q) + id_off);
    end
  end

  task automatic send_req(input logic w, input logic [31:0] a, input logic [255:0] d);
    int t = 0;
    @(negedge clk);
    req_v_i = 1; req_write_i = w; req_addr_i = a; req_data_i = d;
    while (!req_ready_o && t < 100) begin @(negedge clk); t++; end
    vectors++;
    if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL req_accept got %b exp 1", req_ready_o); end
    @(negedge clk);
    req_v_i = 0;
  endtask

  task automatic get_resp(output logic [255:0] d, output logic e);
    int t = 0;
    while (!resp_v_o && t < 300) begin @(negedge clk); t++; end
    vectors++;
    if (resp_v_o !== 1'b1) begin miscompares++; $display("FAIL resp_timeout resp_v got %b exp 1", resp_v_o); end
    d = resp_data_o; e = resp_err_o;
    resp_yumi_i = 1;
    @(negedge clk);
    resp_yumi_i = 0;
  endtask

  task automatic test_reset();
    reset_i = 1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_ready_o, resp_v_o, axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b exp 0", {req_ready_o, resp_v_o, axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o});
    end
    vectors++;
    if ({axi_awid_o, axi_araddr_o, resp_err_o} !== 37'b0) begin
      miscompares++; $display("FAIL reset_regs got id %h addr %h err %b exp 0", axi_awid_o, axi_araddr_o, resp_err_o);
    end
    reset_i = 0;
    @(negedge clk);
    vectors++;
    if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL idle_ready got %b exp 1", req_ready_o); end
  endtask

  task automatic test_write_read();
    logic [255:0] d;
    logic e;
    wn = 0; w_before_aw = 0;
    send_req(1, 32'h100, line1);
    get_resp(d, e);
    vectors++;
    if (e !== 1'b0) begin miscompares++; $display("FAIL wr_err got %b exp 0", e); end
    vectors++;
    if (wn !== 4) begin miscompares++; $display("FAIL wr_beats got %0d exp 4", wn); end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (wd[k] !== line1[k*64 +: 64] || wl[k] !== (k == 3)) begin
        miscompares++; $display("FAIL wr_beat%0d got %h last %b exp %h last %b", k, wd[k], wl[k], line1[k*64 +: 64], k == 3);
      end
    end
    vectors++;
    if (w_before_aw !== 1'b0) begin miscompares++; $display("FAIL w_before_aw got %b exp 0", w_before_aw); end
    vectors++;
    if ({aw_addr_q, aw_len_q, aw_burst_q, aw_id_q, axi_wstrb_o} !== {32'h100, 8'd3, 2'b01, 4'd0, 8'hff}) begin
      miscompares++; $display("FAIL aw_fields got addr %h len %0d burst %b id %0d strb %h", aw_addr_q, aw_len_q, aw_burst_q, aw_id_q, axi_wstrb_o);
    end
    send_req(0, 32'h100, '0);
    get_resp(d, e);
    vectors++;
    if (d !== line1) begin miscompares++; $display("FAIL rd_line got %h exp %h", d, line1); end
    vectors++;
    if (e !== 1'b0) begin miscompares++; $display("FAIL rd_err got %b exp 0", e); end
    vectors++;
    if ({ar_addr_q, ar_len_q, ar_burst_q, ar_id_q} !== {32'h100, 8'd3, 2'b01, 4'd1}) begin
      miscompares++; $display("FAIL ar_fields got addr %h len %0d burst %b id %0d", ar_addr_q, ar_len_q, ar_burst_q, ar_id_q);
    end
  endtask

  task automatic test_backpressure();
    logic [255:0] d;
    logic e;
    stall_en = 1; wn = 0; w_before_aw = 0;
    send_req(1, 32'h200, line2);
    get_resp(d, e);
    vectors++;
    if (wn !== 4 || e !== 1'b0 || w_before_aw !== 1'b0) begin
      miscompares++; $display("FAIL bp_write got beats %0d err %b early_w %b exp 4 0 0", wn, e, w_before_aw);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (wd[k] !== line2[k*64 +: 64] || wl[k] !== (k == 3)) begin
        miscompares++; $display("FAIL bp_beat%0d got %h last %b exp %h", k, wd[k], wl[k], line2[k*64 +: 64]);
      end
    end
    send_req(0, 32'h200, '0);
    get_resp(d, e);
    vectors++;
    if (d !== line2 || e !== 1'b0) begin miscompares++; $display("FAIL bp_read got %h err %b exp %h 0", d, e, line2); end
    stall_en = 0;
  endtask

  task automatic test_unaligned();
    logic [255:0] d;
    logic e;
    send_req(0, 32'h107, '0);
    get_resp(d, e);
    vectors++;
    if (ar_addr_q !== 32'h100) begin miscompares++; $display("FAIL unaligned_araddr got %h exp 00000100", ar_addr_q); end
    vectors++;
    if (d !== line1) begin miscompares++; $display("FAIL unaligned_data got %h exp %h", d, line1); end
  endtask

  task automatic test_rresp_err();
    logic [255:0] d;
    logic e;
    err_beat = 1;
    send_req(0, 32'h100, '0);
    get_resp(d, e);
    err_beat = -1;
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL rresp_err got %b exp 1", e); end
    send_req(0, 32'h100, '0);
    get_resp(d, e);
    vectors++;
    if (e !== 1'b0 || d !== line1) begin miscompares++; $display("FAIL err_cleared got err %b data %h exp 0 %h", e, d, line1); end
  endtask

  task automatic test_early_rlast();
    logic [255:0] d;
    logic e;
    early_beat = 2;
    send_req(0, 32'h200, '0);
    get_resp(d, e);
    early_beat = -1;
    vectors++;
    if (e !== 1'b1) begin miscompares++; $display("FAIL early_rlast_err got %b exp 1", e); end
    vectors++;
    if (d !== line2 || rd_active !== 1'b0) begin miscompares++; $display("FAIL early_rlast_beats got %h open %b exp %h 0", d, rd_active, line2); end
    vectors++;
    if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL early_rlast_idle got %b exp 1", req_ready_o); end
  endtask

  task automatic test_id_check();
    logic [255:0] d;
    logic e, exp_e;
`ifdef BSG_AXI_LINE_MASTER_ID_CHECK_EN
    exp_e = 1'b1;
`else
    exp_e = 1'b0;
`endif
    id_off = 1;
    send_req(0, 32'h100, '0);
    get_resp(d, e);
    id_off = 0;
    vectors++;
    if (e !== exp_e) begin miscompares++; $display("FAIL rid_mismatch_err got %b exp %b", e, exp_e); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] d;
    logic e, seen;
    int t = 0;
    send_req(0, 32'h100, '0);
    do begin @(posedge clk); #2; t++; end while (!(rd_active && rbeat >= 2) && t < 100);
    vectors++;
    if (rbeat !== 2) begin miscompares++; $display("FAIL mid_beats got %0d exp 2", rbeat); end
    reset_i = 1;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({resp_v_o, axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o} !== 6'b0) begin
      miscompares++; $display("FAIL mid_reset_ctrl got %b exp 0", {resp_v_o, axi_awvalid_o, axi_wvalid_o, axi_bready_o, axi_arvalid_o, axi_rready_o});
    end
    reset_i = 0;
    seen = 0;
    repeat (10) begin @(negedge clk); if (resp_v_o) seen = 1; end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL mid_no_resp got %b exp 0", seen); end
    send_req(0, 32'h200, '0);
    get_resp(d, e);
    vectors++;
    if (d !== line2 || e !== 1'b0 || ar_id_q !== 4'd0) begin
      miscompares++; $display("FAIL post_reset_read got %h err %b id %0d exp %h 0 0", d, e, ar_id_q, line2);
    end
  endtask

  initial begin
    reset_i = 1; req_v_i = 0; req_write_i = 0; req_addr_i = 0; req_data_i = 0; resp_yumi_i = 0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_unaligned();
    test_rresp_err();
    test_early_rlast();
    test_id_check();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
